// File: rtl/key_event_scheduler_if.sv
// Key event channel: valid/ready handshake carrying key index and event type,
// plus the pending-overwrite drop pulse.
interface key_event_scheduler_if #(
  parameter int N_KEYS = 4
) ();
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic          ev_valid;
  logic          ev_ready;
  logic [KW-1:0] ev_key;
  logic [1:0]    ev_type;
  logic          ev_drop;

  modport master (
    output ev_valid,
    output ev_key,
    output ev_type,
    output ev_drop,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_key,
    input  ev_type,
    input  ev_drop,
    output ev_ready
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Debounces N_KEYS raw key lines and arbitrates press/release events round-robin onto
// one valid/ready channel. Define KEY_AUTOREPEAT_EN to add held-key repeat events.
module key_event_scheduler #(
  parameter int N_KEYS      = 4,
  parameter int TICK_DIV    = 16,
  parameter int STABLE_CNT  = 4,
  parameter int REPEAT_DLY  = 32,
  parameter int REPEAT_RATE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_KEYS-1:0]     key_raw,
  output logic [N_KEYS-1:0]     key_state,
  key_event_scheduler_if.master ev_if
);
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = 4;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] EV_REPEAT = 2'b10;
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD_DLY = 2'd1,
    ST_HELD_RPT = 2'd2
  } key_st_e;
  localparam key_st_e ST_PRESS_ENTRY = ST_HELD_DLY;
`else
  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_st_e;
  localparam key_st_e ST_PRESS_ENTRY = ST_PRESSED;
`endif

  // An out-of-range parameter set shows up as this named block in the elaborated hierarchy.
  if (N_KEYS < 2 || N_KEYS > 16 || TICK_DIV < 2 || STABLE_CNT < 1 || STABLE_CNT > 15 ||
      REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_out_of_range
  end

  logic [N_KEYS-1:0] sync1_reg;
  logic [N_KEYS-1:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  logic [PW-1:0] presc_reg;
  logic          tick;

  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
    end
  end

  logic [N_KEYS-1:0] fire;
  logic [1:0]        fire_type [N_KEYS];

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    key_st_e       st_reg, st_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pressed;
    logic          disagree;
    logic          qual_c;
    logic          fire_c;
    logic [1:0]    type_c;
`ifdef KEY_AUTOREPEAT_EN
    logic [RW-1:0] rpt_reg, rpt_next;
`endif

    assign pressed  = (st_reg != ST_RELEASED);
    assign disagree = (sync2_reg[gi] != pressed);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_reg  <= ST_RELEASED;
        cnt_reg <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_reg <= '0;
`endif
      end else begin
        st_reg  <= st_next;
        cnt_reg <= cnt_next;
`ifdef KEY_AUTOREPEAT_EN
        rpt_reg <= rpt_next;
`endif
      end
    end

    always_comb begin
      st_next  = st_reg;
      cnt_next = cnt_reg;
      fire_c   = 1'b0;
      type_c   = EV_PRESS;
`ifdef KEY_AUTOREPEAT_EN
      rpt_next = rpt_reg;
`endif
      qual_c = tick && disagree && (cnt_reg == CW'(STABLE_CNT - 1));
      // One agreeing tick restarts qualification from zero.
      if (tick) begin
        cnt_next = (disagree && !qual_c) ? cnt_reg + 1'b1 : '0;
      end
      if (qual_c) begin
        fire_c = 1'b1;
        if (pressed) begin
          st_next = ST_RELEASED;
          type_c  = EV_RELEASE;
        end else begin
          st_next = ST_PRESS_ENTRY;
          type_c  = EV_PRESS;
        end
`ifdef KEY_AUTOREPEAT_EN
        rpt_next = '0;
      end else if (tick) begin
        case (st_reg)
          ST_HELD_DLY: begin
            if (rpt_reg == RW'(REPEAT_DLY - 1)) begin
              rpt_next = '0;
              st_next  = ST_HELD_RPT;
              fire_c   = 1'b1;
              type_c   = EV_REPEAT;
            end else begin
              rpt_next = rpt_reg + 1'b1;
            end
          end
          ST_HELD_RPT: begin
            if (rpt_reg == RW'(REPEAT_RATE - 1)) begin
              rpt_next = '0;
              fire_c   = 1'b1;
              type_c   = EV_REPEAT;
            end else begin
              rpt_next = rpt_reg + 1'b1;
            end
          end
          default: rpt_next = '0;
        endcase
`endif
      end
    end

    assign key_state[gi] = pressed;
    assign fire[gi]      = fire_c;
    assign fire_type[gi] = type_c;
  end

  logic [N_KEYS-1:0] pend_reg, pend_next;
  logic [1:0]        ptype_reg [N_KEYS];
  logic [KW-1:0]     ptr_reg;
  logic [KW-1:0]     cand [N_KEYS];
  logic [KW-1:0]     grant_idx;
  logic              grant_found;
  logic              load;
  logic              drop_c;
  logic              ev_valid_reg;
  logic              ev_drop_reg;
  logic [KW-1:0]     ev_key_reg;
  logic [1:0]        ev_type_reg;

  assign load = !ev_valid_reg || ev_if.ev_ready;

  // cand[i] is the i-th key in search order, starting just after the last grant.
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_cand
    logic [KW:0] sum;
    assign sum      = {1'b0, ptr_reg} + (KW+1)'(gi + 1);
    assign cand[gi] = (sum >= (KW+1)'(N_KEYS)) ? KW'(sum - (KW+1)'(N_KEYS)) : sum[KW-1:0];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!grant_found && pend_reg[cand[i]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[i];
      end
    end
  end

  // A fresh event re-arms its slot; it only counts as a drop if the old one was not taken.
  always_comb begin
    pend_next = pend_reg;
    drop_c    = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (load && grant_found && (grant_idx == KW'(k))) begin
        pend_next[k] = 1'b0;
      end
      if (fire[k]) begin
        if (pend_reg[k] && !(load && grant_found && (grant_idx == KW'(k)))) begin
          drop_c = 1'b1;
        end
        pend_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg     <= '0;
      ptr_reg      <= KW'(N_KEYS - 1);
      ev_valid_reg <= 1'b0;
      ev_key_reg   <= '0;
      ev_type_reg  <= 2'b00;
      ev_drop_reg  <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        ptype_reg[k] <= 2'b00;
      end
    end else begin
      pend_reg    <= pend_next;
      ev_drop_reg <= drop_c;
      for (int k = 0; k < N_KEYS; k++) begin
        if (fire[k]) begin
          ptype_reg[k] <= fire_type[k];
        end
      end
      if (load) begin
        if (grant_found) begin
          ev_valid_reg <= 1'b1;
          ev_key_reg   <= grant_idx;
          ev_type_reg  <= ptype_reg[grant_idx];
          ptr_reg      <= grant_idx;
        end else begin
          ev_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign ev_if.ev_valid = ev_valid_reg;
  assign ev_if.ev_key   = ev_key_reg;
  assign ev_if.ev_type  = ev_type_reg;
  assign ev_if.ev_drop  = ev_drop_reg;
endmodule
